bpf_edge_slicer: RTL and testbench

Receive-path slicer placed directly downstream of the band-pass FIR in the Rx AD port chain. Consumes the filter's signed sample stream and its valid strobe, removes residual DC, and slices the centred signal with programmable hysteresis. Emits one record per level transition: new level plus run length in samples. Feeds the FM0/Miller symbol decoder.

---
 rtl/bpf_edge_slicer.sv | 201 ++++++++++++++++++++
 tb/tb_bpf_edge_slicer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpf_edge_slicer.sv
// Edge slicer after the Rx band-pass FIR: removes DC, slices with hysteresis
// and emits one {level, run length} record per level transition.
//
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous active-high reset
//   set_speed_i  link-speed select; any change restarts the slicer
//   hyst_i       unsigned hysteresis half-width, captured with each sample
//   valid_i      input sample strobe
//   data_i       signed filtered sample
//   valid_o      one-cycle pulse per detected edge
//   level_o      level after the edge (held)
//   width_o      samples in the run that just ended (held)
//   ovf_o        width_o was clamped at its maximum
//   lock_o       high while in HIGH or LOW
//
// Build option: define BPF_EDGE_SLICER_DC_TRACK_EN to include the DC tracker
// and the long settle phase; otherwise samples are sliced as-is.

module bpf_edge_slicer #(
    parameter int SET_DATA_WIDTH = 12,
    parameter int SET_CNT_WIDTH  = 10,
    parameter int SET_AVG_LG     = 6
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [2:0]                       set_speed_i,
    input  logic [SET_DATA_WIDTH-2:0]        hyst_i,
    input  logic                             valid_i,
    input  logic signed [SET_DATA_WIDTH-1:0] data_i,
    output logic                             valid_o,
    output logic                             level_o,
    output logic [SET_CNT_WIDTH-1:0]         width_o,
    output logic                             ovf_o,
    output logic                             lock_o
);

    localparam int DW = SET_DATA_WIDTH;
    localparam int CW = SET_CNT_WIDTH;
    localparam int AL = SET_AVG_LG;

`ifdef BPF_EDGE_SLICER_DC_TRACK_EN
    localparam logic [AL-1:0] SETTLE_LAST = '1;
`else
    localparam logic [AL-1:0] SETTLE_LAST = '0;
`endif
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        SETTLE,
        HUNT,
        HIGH,
        LOW
    } state_t;

    state_t state_q;

    logic [2:0]         speed_q;
    logic               speed_chg;
    logic               accept;
    logic signed [DW:0] c_now;
    logic signed [DW:0] c_q;
    logic signed [DW:0] h_q;
    logic signed [DW:0] neg_h;
    logic               v0_q;
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      cnt_inc;
    logic               cnt_sat;
    logic [AL-1:0]      settle_q;

    assign speed_chg = (speed_q != set_speed_i);
    // A sample arriving with a speed change belongs to the old link setup.
    assign accept    = valid_i && !speed_chg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            speed_q <= '0;
        end else begin
            speed_q <= set_speed_i;
        end
    end

`ifdef BPF_EDGE_SLICER_DC_TRACK_EN
    localparam int AW = SET_DATA_WIDTH + SET_AVG_LG;

    logic signed [AW-1:0] dc_q;
    logic signed [AW-1:0] est;
    logic signed [AW-1:0] x_ext;
    logic signed [AW-1:0] diff;

    assign est   = dc_q >>> AL;
    assign x_ext = {{AL{data_i[DW-1]}}, data_i};
    // The centred sample and the tracker step are the same difference.
    assign diff  = x_ext - est;
    assign c_now = diff[DW:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dc_q <= '0;
        end else if (speed_chg) begin
            dc_q <= '0;
        end else if (valid_i) begin
            dc_q <= dc_q + diff;
        end
    end
`else
    assign c_now = {data_i[DW-1], data_i};
`endif

    // Stage 0: centred sample and its hysteresis, plus valid flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v0_q <= 1'b0;
            c_q  <= '0;
            h_q  <= '0;
        end else begin
            v0_q <= accept;
            if (accept) begin
                c_q <= c_now;
                h_q <= $signed({2'b00, hyst_i});
            end
        end
    end

    assign neg_h   = -h_q;
    assign cnt_sat = (cnt_q == CNT_MAX);
    assign cnt_inc = cnt_sat ? CNT_MAX : cnt_q + 1'b1;

    // Stage 1: slicer FSM and registered record outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= SETTLE;
            cnt_q    <= '0;
            settle_q <= '0;
            valid_o  <= 1'b0;
            level_o  <= 1'b0;
            width_o  <= '0;
            ovf_o    <= 1'b0;
            lock_o   <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (speed_chg) begin
                // Overrides any sample sitting in stage 0 this cycle.
                state_q  <= SETTLE;
                cnt_q    <= '0;
                settle_q <= '0;
                lock_o   <= 1'b0;
            end else if (v0_q) begin
                unique case (state_q)
                    SETTLE: begin
                        if (settle_q == SETTLE_LAST) begin
                            state_q  <= HUNT;
                            settle_q <= '0;
                        end else begin
                            settle_q <= settle_q + 1'b1;
                        end
                    end
                    HUNT: begin
                        if (c_q > h_q) begin
                            state_q <= HIGH;
                            cnt_q   <= '0;
                            lock_o  <= 1'b1;
                        end else if (c_q < neg_h) begin
                            state_q <= LOW;
                            cnt_q   <= '0;
                            lock_o  <= 1'b1;
                        end
                    end
                    HIGH: begin
                        if (c_q < neg_h) begin
                            valid_o <= 1'b1;
                            level_o <= 1'b0;
                            width_o <= cnt_inc;
                            ovf_o   <= cnt_sat;
                            state_q <= LOW;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    LOW: begin
                        if (c_q > h_q) begin
                            valid_o <= 1'b1;
                            level_o <= 1'b1;
                            width_o <= cnt_inc;
                            ovf_o   <= cnt_sat;
                            state_q <= HIGH;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    default: begin
                        state_q <= SETTLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bpf_edge_slicer.sv
// Testbench for bpf_edge_slicer: vector table of sample runs, scoreboard of
// expected edge records, and hand-written speed-change / reset sequences.

module tb_bpf_edge_slicer;

    localparam int DW = 12;
    localparam int CW = 4;
    localparam int AL = 6;
`ifdef BPF_EDGE_SLICER_DC_TRACK_EN
    localparam int SETTLE_N = 64;
`else
    localparam int SETTLE_N = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    speed = 3'd0;
    logic [DW-2:0] hyst = 11'd100;
    logic          valid = 1'b0;
    logic [DW-1:0] data = '0;
    logic          valid_o;
    logic          level_o;
    logic [CW-1:0] width_o;
    logic          ovf_o;
    logic          lock_o;

    bpf_edge_slicer #(
        .SET_DATA_WIDTH(DW),
        .SET_CNT_WIDTH (CW),
        .SET_AVG_LG    (AL)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .set_speed_i(speed),
        .hyst_i     (hyst),
        .valid_i    (valid),
        .data_i     (data),
        .valid_o    (valid_o),
        .level_o    (level_o),
        .width_o    (width_o),
        .ovf_o      (ovf_o),
        .lock_o     (lock_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hyst;
        int data;
        int n;
        int gap;
        bit rec;
        bit lvl;
        int wid;
        bit ovf;
    } vec_t;

    typedef struct {
        bit lvl;
        int wid;
        bit ovf;
        int cyc;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   sb_on = 1'b1;
    bit   dc_late = 1'b0;
    int   rec_n = 0;
    int   bad_n = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, act, want);
        end
    endtask

    // Scoreboard: each record must appear on its expected cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (sb_on) begin
                if (valid_o) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_record got lvl=%0d wid=%0d want none",
                                 level_o, width_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rec_level", int'(level_o), int'(e.lvl));
                        chk("rec_width", int'(width_o), e.wid);
                        chk("rec_ovf", int'(ovf_o), int'(e.ovf));
                        chk("rec_cycle", cyc, e.cyc);
                    end
                end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                    e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_record got none want lvl=%0d wid=%0d at cyc %0d",
                             e.lvl, e.wid, e.cyc);
                end
            end else if (valid_o) begin
                rec_n++;
                if (dc_late && width_o != 4'd8) bad_n++;
            end
        end
    end

    task automatic send(input int h, input int d, input bit rec,
                        input bit lvl, input int wid, input bit ovf);
        @(posedge clk);
        #1;
        hyst  = 11'(h);
        data  = 12'(d);
        valid = 1'b1;
        if (rec) exp_q.push_back('{lvl, wid, ovf, cyc + 2});
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        // hyst, data, n, gap, rec, lvl, wid, ovf
        tbl.push_back('{100, 0, SETTLE_N, 0, 0, 0, 0, 0});
        tbl.push_back('{100, 500, 8, 0, 0, 0, 0, 0});
        tbl.push_back('{100, -500, 8, 0, 1, 0, 8, 0});
        tbl.push_back('{100, 500, 8, 0, 1, 1, 8, 0});
        tbl.push_back('{100, -500, 8, 0, 1, 0, 8, 0});
        tbl.push_back('{100, 500, 8, 0, 1, 1, 8, 0});
        tbl.push_back('{100, -500, 1, 0, 1, 0, 8, 0});
        tbl.push_back('{100, 500, 1, 0, 1, 1, 1, 0});
        tbl.push_back('{100, 500, 40, 0, 0, 0, 0, 0});
        tbl.push_back('{100, -500, 1, 0, 1, 0, 15, 1});
        tbl.push_back('{100, -500, 13, 0, 0, 0, 0, 0});
        tbl.push_back('{100, 500, 1, 0, 1, 1, 14, 0});
        tbl.push_back('{100, 500, 14, 0, 0, 0, 0, 0});
        tbl.push_back('{100, -500, 1, 0, 1, 0, 15, 0});
        tbl.push_back('{100, -500, 3, 1, 0, 0, 0, 0});
        tbl.push_back('{100, 500, 1, 1, 1, 1, 4, 0});
`ifndef BPF_EDGE_SLICER_DC_TRACK_EN
        tbl.push_back('{100, -101, 1, 0, 1, 0, 1, 0});
        tbl.push_back('{100, 101, 1, 0, 1, 1, 1, 0});
        tbl.push_back('{100, -100, 2, 0, 0, 0, 0, 0});
        tbl.push_back('{100, -101, 1, 0, 1, 0, 3, 0});
        tbl.push_back('{100, 100, 2, 0, 0, 0, 0, 0});
        tbl.push_back('{100, 101, 1, 0, 1, 1, 3, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{0, -1, 1, 0, 1, 0, 2, 0});
        tbl.push_back('{100, 500, 1, 0, 1, 1, 1, 0});
`endif

        repeat (2) @(negedge clk);
        chk("reset_outputs",
            int'({valid_o, level_o, width_o, ovf_o, lock_o}), 0);
        rst = 1'b0;

        foreach (tbl[r]) begin
            for (int k = 0; k < tbl[r].n; k++) begin
                send(tbl[r].hyst, tbl[r].data, tbl[r].rec && k == 0,
                     tbl[r].lvl, tbl[r].wid, tbl[r].ovf);
                repeat (tbl[r].gap) idle();
            end
        end
        idle();
        repeat (3) @(negedge clk);
        chk("table_drained", exp_q.size(), 0);
        chk("lock_after_table", int'(lock_o), 1);

        // Speed change on the crossing sample: no record, lock drops.
        for (int k = 0; k < 4; k++) send(100, 500, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        speed = 3'd1;
        data  = -12'sd500;
        valid = 1'b1;
        @(negedge clk);
        chk("spd_lock_before", int'(lock_o), 1);
        idle();
        @(negedge clk);
        chk("spd_lock_dropped", int'(lock_o), 0);
        for (int k = 0; k < SETTLE_N; k++) send(100, -500, 0, 0, 0, 0);
        idle();
        idle();
        @(negedge clk);
        chk("spd_lock_in_settle", int'(lock_o), 0);
        send(100, 500, 0, 0, 0, 0);
        idle();
        idle();
        @(negedge clk);
        chk("spd_lock_hunt", int'(lock_o), 1);
        for (int k = 0; k < 7; k++) send(100, 500, 0, 0, 0, 0);
        send(100, -500, 1, 0, 8, 0);

        // Asynchronous reset in LOW with five samples counted.
        for (int k = 0; k < 5; k++) send(100, -500, 0, 0, 0, 0);
        repeat (3) idle();
        @(posedge clk);
        #3;
        chk("pre_rst_lock", int'(lock_o), 1);
        rst = 1'b1;
        #1;
        chk("rst_async_out",
            int'({valid_o, level_o, width_o, ovf_o, lock_o}), 0);
        #2;
        rst = 1'b0;
        for (int k = 0; k < SETTLE_N; k++) send(100, -500, 0, 0, 0, 0);
        idle();
        idle();
        @(negedge clk);
        chk("rst_lock_settle", int'(lock_o), 0);
        send(100, 500, 0, 0, 0, 0);
        for (int k = 0; k < 7; k++) send(100, 500, 0, 0, 0, 0);
        send(100, -500, 1, 0, 8, 0);
        repeat (4) idle();
        chk("rst_seq_drained", exp_q.size(), 0);

`ifdef BPF_EDGE_SLICER_DC_TRACK_EN
        // DC offset 300, sample every 2nd cycle.
        sb_on = 1'b0;
        @(posedge clk);
        #1;
        speed = 3'd2;
        valid = 1'b0;
        for (int i = 0; i < 264; i++) begin
            send(100, (((i / 8) % 2 == 0) ? 500 : -500) + 300, 0, 0, 0, 0);
            idle();
            if (i == 63) begin
                idle();
                idle();
                chk("dc_settle_quiet", rec_n, 0);
            end
            if (i == 127) dc_late = 1'b1;
        end
        repeat (4) idle();
        chk("dc_records_seen", int'(rec_n > 0), 1);
        chk("dc_width_converged", bad_n, 0);
`endif

        repeat (2) idle();
        chk("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
